// File: rtl/data_demux1to4_reg_if.sv
// Bus interface for the registered 1-to-4 data demultiplexer.
// master: the source/consumer side; slave: the demux itself.
// The xfer_count signal exists only when DEMUX_COUNT_EN is defined.
interface data_demux1to4_reg_if #(
  parameter int DATA_BUS_WIDTH = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_sel;
  logic [DATA_BUS_WIDTH-1:0] in_data;
  logic [3:0]                out_valid;
  logic [3:0]                out_ready;
  logic [DATA_BUS_WIDTH-1:0] out_data0;
  logic [DATA_BUS_WIDTH-1:0] out_data1;
  logic [DATA_BUS_WIDTH-1:0] out_data2;
  logic [DATA_BUS_WIDTH-1:0] out_data3;
  logic                      any_pending;
`ifdef DEMUX_COUNT_EN
  logic [31:0]               xfer_count;
`endif

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           any_pending
`ifdef DEMUX_COUNT_EN
    , output xfer_count
`endif
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           any_pending
`ifdef DEMUX_COUNT_EN
    , input xfer_count
`endif
  );
endinterface

// File: rtl/data_demux1to4_reg.sv
// Registered 1-to-4 data demultiplexer: steers one word per cycle from the
// shared result bus into one of four one-entry holding slots, each with its
// own valid/ready handshake toward its consumer.
// Optional macro DEMUX_COUNT_EN adds xfer_count: four wrapping 8-bit
// per-slot drain counters (slot i at bits [8i+7:8i]).
//
// Per-slot state (held in r_valid[i]):
//   state | meaning
//   EMPTY | r_valid[i]=0, slot may be loaded
//   FULL  | r_valid[i]=1, word waiting for consumer i
module data_demux1to4_reg #(
  parameter int DATA_BUS_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  data_demux1to4_reg_if.slave   bus
);

  logic [3:0]                r_valid;
  logic [DATA_BUS_WIDTH-1:0] r_data [4];

  logic                      w_in_ready;
  logic                      w_accept;
  logic [3:0]                w_load;
  logic [3:0]                w_drain;

  // A slot can take a word when it is empty or is being drained this cycle.
  assign w_in_ready = !r_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_drain    = r_valid & bus.out_ready;

  // One-hot load strobe for the selected slot.
  always_comb begin
    w_load = 4'b0000;
    if (w_accept) w_load[bus.in_sel] = 1'b1;
  end

  // Slot occupancy: a load wins over a same-edge drain (pass-through).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_valid <= 4'b0000;
    else     r_valid <= w_load | (r_valid & ~w_drain);
  end

  // Slot contents: written only on load, retained after drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_load[i]) r_data[i] <= bus.in_data;
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [7:0] r_cnt [4];

  // Per-slot drain counters, wrapping 255 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_drain[i]) r_cnt[i] <= r_cnt[i] + 8'd1;
    end
  end

  assign bus.xfer_count = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_valid;
  assign bus.out_data0   = r_data[0];
  assign bus.out_data1   = r_data[1];
  assign bus.out_data2   = r_data[2];
  assign bus.out_data3   = r_data[3];
  assign bus.any_pending = |r_valid;

endmodule

// File: tb/tb_data_demux1to4_reg.sv
// Directed self-checking bench for data_demux1to4_reg.
// Inputs change 1 ns after a rising edge; outputs are checked before the next edge.
module tb_data_demux1to4_reg;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  data_demux1to4_reg_if #(.DATA_BUS_WIDTH(16)) bus ();

  data_demux1to4_reg #(.DATA_BUS_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [15:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 4'b0000;
    #1;
    chk("rst_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("rst_pending", {31'd0, bus.any_pending}, 32'h0);
    chk("rst_data0", {16'd0, bus.out_data0}, 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = s[1:0];
      #1;
      chk("ready_after_rst", {31'd0, bus.in_ready}, 32'h1);
    end

    // basic delivery to slot 2
    send(2'd2, 16'hBEEF);
    chk("basic_valid", {28'd0, bus.out_valid}, 32'h4);
    chk("basic_data2", {16'd0, bus.out_data2}, 32'hBEEF);
    chk("basic_pending", {31'd0, bus.any_pending}, 32'h1);
    bus.out_ready = 4'b0100;
    cyc();
    bus.out_ready = 4'b0000;
    chk("basic_drained", {28'd0, bus.out_valid}, 32'h0);
    chk("basic_retained", {16'd0, bus.out_data2}, 32'hBEEF);

    // backpressure on slot 0 blocks only slot 0
    send(2'd0, 16'h1111);
    chk("bp_fill", {28'd0, bus.out_valid}, 32'h1);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_data  = 16'h2222;
    #1;
    chk("bp_ready_low", {31'd0, bus.in_ready}, 32'h0);
    cyc();
    chk("bp_data0_hold", {16'd0, bus.out_data0}, 32'h1111);
    chk("bp_valid_hold", {28'd0, bus.out_valid}, 32'h1);
    bus.in_sel = 2'd1;
    #1;
    chk("bp_other_ready", {31'd0, bus.in_ready}, 32'h1);
    cyc();
    bus.in_valid = 1'b0;
    chk("bp_other_valid", {28'd0, bus.out_valid}, 32'h3);
    chk("bp_other_data1", {16'd0, bus.out_data1}, 32'h2222);
    chk("bp_other_data0", {16'd0, bus.out_data0}, 32'h1111);

    // reset mid-run with slots 1 and 3 full
    send(2'd3, 16'h3333);
    bus.out_ready = 4'b0001;
    cyc();
    bus.out_ready = 4'b0000;
    chk("pre_rst_valid", {28'd0, bus.out_valid}, 32'hA);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("async_rst_pending", {31'd0, bus.any_pending}, 32'h0);
    chk("async_rst_data1", {16'd0, bus.out_data1}, 32'h0);
    chk("async_rst_data3", {16'd0, bus.out_data3}, 32'h0);
    cyc();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = s[1:0];
      #1;
      chk("ready_after_midrst", {31'd0, bus.in_ready}, 32'h1);
    end

    // pass-through on slot 3
    send(2'd3, 16'h0A0A);
    bus.out_ready = 4'b1000;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd3;
    bus.in_data   = 16'h0B0B;
    #1;
    chk("pt_ready", {31'd0, bus.in_ready}, 32'h1);
    cyc();
    chk("pt_valid3", {31'd0, bus.out_valid[3]}, 32'h1);
    chk("pt_data3", {16'd0, bus.out_data3}, 32'h0B0B);
    for (int k = 0; k < 8; k++) begin
      bus.in_data = 16'h0100 + 16'(k);
      #1;
      chk("stream_ready", {31'd0, bus.in_ready}, 32'h1);
      cyc();
      chk("stream_data3", {16'd0, bus.out_data3}, 32'h0100 + k);
    end
    bus.in_valid = 1'b0;
    cyc();
    bus.out_ready = 4'b0000;
    chk("stream_empty", {28'd0, bus.out_valid}, 32'h0);

    // parallel drain of all four slots
    send(2'd0, 16'h0001);
    send(2'd1, 16'h0002);
    send(2'd2, 16'h0003);
    send(2'd3, 16'h0004);
    chk("par_full", {28'd0, bus.out_valid}, 32'hF);
    bus.out_ready = 4'b1111;
    cyc();
    bus.out_ready = 4'b0000;
    chk("par_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("par_pending", {31'd0, bus.any_pending}, 32'h0);
    chk("par_data", {bus.out_data0[7:0], bus.out_data1[7:0], bus.out_data2[7:0], bus.out_data3[7:0]},
        32'h01020304);

`ifdef DEMUX_COUNT_EN
    // slot 3: 10 drains in pass-through + 1 parallel; slots 0..2: 1 each
    chk("cnt_mixed", bus.xfer_count, 32'h0B010101);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("cnt_rst", bus.xfer_count, 32'h0);
    bus.out_ready = 4'b0010;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd1;
    for (int k = 0; k < 257; k++) begin
      bus.in_data = 16'(k);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc();
    bus.out_ready = 4'b0000;
    chk("cnt_wrap", bus.xfer_count, 32'h00000100);
    rst = 1'b1;
    #1;
    chk("cnt_rst2", bus.xfer_count, 32'h0);
    cyc();
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_demux1to4_reg.md
Name: data_demux1to4_reg

Overview:
- Registered 1-to-4 data demultiplexer. It steers one word from the shared data bus to one of four destination ports.
- Each destination port has its own one-entry holding register and a valid/ready handshake.
- It is the write/distribution end of the 4-to-1 source-select path. It sits between the datapath result bus and up to four consumers (register file write port, memory write buffer, I/O port, spare).
- One clock domain; single-cycle latency.

Parameters:
- DATA_BUS_WIDTH, 16: width of every data port (shared datapath bus width).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a word.
- in_ready  output  1  block can accept the presented word this cycle.
- in_sel  input  2  destination index, 0..3.
- in_data  input  DATA_BUS_WIDTH  word to deliver.
- out_valid  output  4  bit i set means slot i holds an undelivered word.
- out_ready  input  4  bit i set means consumer i takes slot i this cycle.
- out_data0  output  DATA_BUS_WIDTH  slot 0 contents.
- out_data1  output  DATA_BUS_WIDTH  slot 1 contents.
- out_data2  output  DATA_BUS_WIDTH  slot 2 contents.
- out_data3  output  DATA_BUS_WIDTH  slot 3 contents.
- any_pending  output  1  OR of out_valid.

Behaviour:
- Reset: asynchronous and active-high. While rst=1: out_valid=4'b0000, out_data0..3 all zero, any_pending=0. Reset mid-transfer discards every held word, with no partial delivery.
- Per-slot state: EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1).
- in_ready is combinational: in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - Depends only on the selected slot.
  - Never depends on in_valid, so there is no combinational loop.
- Accept: in_valid & in_ready at a rising edge. Next cycle, slot[in_sel] data = in_data and out_valid[in_sel]=1. Latency from input accept to out_valid is 1 cycle.
- Drain: out_valid[i] & out_ready[i] at an edge. Slot i goes EMPTY unless the same slot is loaded on the same edge.
- Slot transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without load.
  - FULL→FULL with new data on simultaneous drain+load (pass-through, full throughput of 1 word/cycle per slot).
- Unselected slots are unaffected by the input side. All four slots may drain on the same edge.
- out_dataN is stable while out_valid[N]=1 and not drained. Its value is retained (not cleared) after drain.
- out_ready[i] while slot i is EMPTY is ignored.
- Source protocol: once in_valid=1, in_sel and in_data must hold until accepted. in_valid must not drop before acceptance.
- Backpressure on one slot blocks only words targeting that slot. There is no reordering across the input: only one word per cycle, in order.
- any_pending is registered-derived: OR of the out_valid flops, no input path.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- When defined:
  - Adds output xfer_count [31:0]: four 8-bit counters, slot i at bits [8i+7:8i].
  - Counter i increments by 1 on every completed drain handshake of slot i.
  - Wraps 255→0 with no saturation.
  - Reset to 0 by rst.
  - Simultaneous drains on several slots increment each counter independently.
- When not defined: the xfer_count port and its counters are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-run with slots 1 and 3 FULL → out_valid=0000, out_data0..3=0, any_pending=0 immediately (before the next clk edge); in_ready=1 for every in_sel once rst=0.
- Basic delivery: in_sel=2, in_data=16'hBEEF, in_valid=1 for one cycle, out_ready=0 → next cycle out_valid=0100, out_data2=BEEF; raise out_ready[2] → following cycle out_valid=0000.
- Backpressure: slot 0 FULL with 16'h1111, out_ready[0]=0, present in_sel=0, in_data=16'h2222 → in_ready=0, out_data0 stays 1111. Present in_sel=1 instead → accepted, out_valid=0011.
- Pass-through: slot 3 FULL with 16'h0A0A, out_ready[3]=1, present in_sel=3, in_data=16'h0B0B → in_ready=1; next cycle out_valid[3]=1, out_data3=0B0B. Stream 8 words back-to-back → 8 drains in 8 cycles, no bubbles.
- Parallel drain: fill all four slots with 16'h0001..16'h0004, then set out_ready=1111 for one cycle → out_valid=0000 and any_pending=0 next cycle; out_data values retained.
- DEMUX_COUNT_EN: 257 drains on slot 1 → xfer_count[15:8]=1 (wrapped), other fields 0; rst → all 0.
